// File: rtl/seg_monitor.sv
// seg_monitor
//   Receive-side checker for the two seven-segment buses driven toward
//   HEX0/HEX1. Samples both buses on the divider tick, waits for a pattern
//   to hold for STABLE_TICKS consecutive samples, then decodes it back into
//   digit values or flags it as illegal. Counts accepted value changes.
//
//   Build option: define SEG_MONITOR_BLANK_EN to treat 7'h7F (all segments
//   off) as a legal code that decodes to 0. A fully blank pair is still
//   locked but is not counted as a change.
//
// Ports
//   clock    system clock (CLOCK50 domain)
//   reset    synchronous, active-high
//   tick     one-cycle sample strobe
//   hex0     low-digit segments, active-low, {g,f,e,d,c,b,a}
//   hex1     high-digit segments, same encoding
//   val0     last accepted low digit
//   val1     last accepted high digit
//   valid    accepted pattern currently held
//   err      illegal pattern accepted
//   changes  accepted value changes, wraps 255->0
//   led      {err, valid, settling}
module seg_monitor #(
  parameter int unsigned STABLE_TICKS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic [6:0] hex0,
  input  logic [6:0] hex1,
  output logic [3:0] val0,
  output logic [3:0] val1,
  output logic       valid,
  output logic       err,
  output logic [7:0] changes,
  output logic [2:0] led
);

  localparam logic [3:0] ST = 4'(STABLE_TICKS);

  typedef enum logic [1:0] {SETTLE, LOCKED, FAULT} state_t;

  state_t      state, state_nx;
  logic [13:0] cand;
  logic [3:0]  stab, stab_nx;
  logic        seen;        // a non-blank pair has been accepted since reset

  logic [13:0] sample;
  logic        differ, accept, legal, blank_pair, bump;
  logic [4:0]  d0, d1;      // {legal, digit}

  // Segment pattern -> {legal, digit}.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'h40:   decode = {1'b1, 4'h0};
      7'h79:   decode = {1'b1, 4'h1};
      7'h24:   decode = {1'b1, 4'h2};
      7'h30:   decode = {1'b1, 4'h3};
      7'h19:   decode = {1'b1, 4'h4};
      7'h12:   decode = {1'b1, 4'h5};
      7'h02:   decode = {1'b1, 4'h6};
      7'h78:   decode = {1'b1, 4'h7};
      7'h00:   decode = {1'b1, 4'h8};
      7'h10:   decode = {1'b1, 4'h9};
      7'h08:   decode = {1'b1, 4'hA};
      7'h03:   decode = {1'b1, 4'hB};
      7'h46:   decode = {1'b1, 4'hC};
      7'h21:   decode = {1'b1, 4'hD};
      7'h06:   decode = {1'b1, 4'hE};
      7'h0E:   decode = {1'b1, 4'hF};
`ifdef SEG_MONITOR_BLANK_EN
      7'h7F:   decode = {1'b1, 4'h0};
`endif
      default: decode = 5'b0;
    endcase
  endfunction

  always_comb begin
    sample     = {hex1, hex0};
    differ     = (sample != cand);
    d0         = decode(hex0);
    d1         = decode(hex1);
    legal      = d0[4] & d1[4];
`ifdef SEG_MONITOR_BLANK_EN
    blank_pair = (sample == 14'h3FFF);
`else
    blank_pair = 1'b0;
`endif
    if (differ)
      stab_nx = 4'd1;
    else if (stab >= ST)
      stab_nx = stab;
    else
      stab_nx = stab + 4'd1;

    // A differing sample re-enters SETTLE on this same tick, so with
    // STABLE_TICKS=1 it is evaluated for acceptance immediately.
    accept = tick && (state == SETTLE || differ) && (stab_nx == ST);
    bump   = accept && legal && !blank_pair &&
             (!seen || {d1[3:0], d0[3:0]} != {val1, val0});

    state_nx = state;
    if (tick && differ)
      state_nx = SETTLE;
    if (accept)
      state_nx = legal ? LOCKED : FAULT;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= SETTLE;
      cand    <= 14'h3FFF;
      stab    <= '0;
      val0    <= '0;
      val1    <= '0;
      changes <= '0;
      seen    <= 1'b0;
    end else if (tick) begin
      state <= state_nx;
      cand  <= sample;
      stab  <= stab_nx;
      if (accept && legal) begin
        val0 <= d0[3:0];
        val1 <= d1[3:0];
      end
      if (bump) begin
        changes <= changes + 8'd1;
        seen    <= 1'b1;
      end
    end
  end

  always_comb begin
    valid = (state == LOCKED);
    err   = (state == FAULT);
    led   = {err, valid, state == SETTLE};
  end

endmodule

// File: tb/tb_seg_monitor.sv
module tb_seg_monitor;

  logic       clock = 1'b0;
  logic       reset, tick;
  logic [6:0] hex0, hex1;

  logic [3:0] a_val0, a_val1, b_val0, b_val1;
  logic       a_valid, a_err, b_valid, b_err;
  logic [7:0] a_changes, b_changes;
  logic [2:0] a_led, b_led;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  seg_monitor #(.STABLE_TICKS(4)) u4 (
    .clock(clock), .reset(reset), .tick(tick), .hex0(hex0), .hex1(hex1),
    .val0(a_val0), .val1(a_val1), .valid(a_valid), .err(a_err),
    .changes(a_changes), .led(a_led)
  );

  seg_monitor #(.STABLE_TICKS(1)) u1 (
    .clock(clock), .reset(reset), .tick(tick), .hex0(hex0), .hex1(hex1),
    .val0(b_val0), .val1(b_val1), .valid(b_valid), .err(b_err),
    .changes(b_changes), .led(b_led)
  );

  // Packed observation: {val1, val0, valid, err, changes, led}
  typedef struct {
    logic        rst;
    logic        tk;
    logic [6:0]  h1;
    logic [6:0]  h0;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [20:0] pk(input logic [3:0] v1, input logic [3:0] v0,
                                     input logic vl, input logic er,
                                     input logic [7:0] ch, input logic [2:0] ld);
    return {v1, v0, vl, er, ch, ld};
  endfunction

  function automatic void add(input logic rst, input logic tk, input logic [6:0] h1,
                              input logic [6:0] h0, input logic [20:0] exp);
    vec_t v;
    v.rst = rst; v.tk = tk; v.h1 = h1; v.h0 = h0; v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic step(input logic rst, input logic tk, input logic [6:0] h1,
                      input logic [6:0] h0);
    @(negedge clock);
    reset = rst; tick = tk; hex1 = h1; hex0 = h0;
    @(posedge clock);
    #1;
  endtask

  task automatic chk4(input string name, input logic [20:0] exp);
    logic [20:0] act;
    act = {a_val1, a_val0, a_valid, a_err, a_changes, a_led};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (ST=4): got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic [20:0] exp);
    logic [20:0] act;
    act = {b_val1, b_val0, b_valid, b_err, b_changes, b_led};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (ST=1): got %h required %h", name, act, exp);
    end
  endtask

  localparam logic [20:0] RST_EXP = {4'h0, 4'h0, 1'b0, 1'b0, 8'd0, 3'b001};

  initial begin
    reset = 1'b1; tick = 1'b0; hex0 = 7'h7F; hex1 = 7'h7F;

    // Reset and first acceptance
    add(1, 0, 7'h24, 7'h79, RST_EXP);
    for (int i = 0; i < 3; i++) add(0, 1, 7'h24, 7'h79, RST_EXP);
    add(0, 1, 7'h24, 7'h79, pk(4'h2, 4'h1, 1, 0, 8'd1, 3'b010));
    add(0, 0, 7'h30, 7'h19, pk(4'h2, 4'h1, 1, 0, 8'd1, 3'b010));
    // Glitch rejection
    add(0, 1, 7'h30, 7'h19, pk(4'h2, 4'h1, 0, 0, 8'd1, 3'b001));
    add(0, 1, 7'h30, 7'h19, pk(4'h2, 4'h1, 0, 0, 8'd1, 3'b001));
    add(0, 1, 7'h00, 7'h00, pk(4'h2, 4'h1, 0, 0, 8'd1, 3'b001));
    for (int i = 0; i < 3; i++) add(0, 1, 7'h30, 7'h19, pk(4'h2, 4'h1, 0, 0, 8'd1, 3'b001));
    add(0, 1, 7'h30, 7'h19, pk(4'h3, 4'h4, 1, 0, 8'd2, 3'b010));
    // Illegal pattern, then recovery
    for (int i = 0; i < 3; i++) add(0, 1, 7'h30, 7'h7E, pk(4'h3, 4'h4, 0, 0, 8'd2, 3'b001));
    add(0, 1, 7'h30, 7'h7E, pk(4'h3, 4'h4, 0, 1, 8'd2, 3'b100));
    for (int i = 0; i < 3; i++) add(0, 1, 7'h40, 7'h40, pk(4'h3, 4'h4, 0, 0, 8'd2, 3'b001));
    add(0, 1, 7'h40, 7'h40, pk(4'h0, 4'h0, 1, 0, 8'd3, 3'b010));
    // Change counting
    for (int i = 0; i < 3; i++) add(0, 1, 7'h08, 7'h0E, pk(4'h0, 4'h0, 0, 0, 8'd3, 3'b001));
    add(0, 1, 7'h08, 7'h0E, pk(4'hA, 4'hF, 1, 0, 8'd4, 3'b010));
    add(0, 1, 7'h08, 7'h00, pk(4'hA, 4'hF, 0, 0, 8'd4, 3'b001));
    for (int i = 0; i < 3; i++) add(0, 1, 7'h08, 7'h0E, pk(4'hA, 4'hF, 0, 0, 8'd4, 3'b001));
    add(0, 1, 7'h08, 7'h0E, pk(4'hA, 4'hF, 1, 0, 8'd4, 3'b010));
    for (int i = 0; i < 3; i++) add(0, 1, 7'h21, 7'h06, pk(4'hA, 4'hF, 0, 0, 8'd4, 3'b001));
    add(0, 1, 7'h21, 7'h06, pk(4'hD, 4'hE, 1, 0, 8'd5, 3'b010));
    add(0, 1, 7'h21, 7'h06, pk(4'hD, 4'hE, 1, 0, 8'd5, 3'b010));
    // Blank handling
    for (int i = 0; i < 3; i++) add(0, 1, 7'h7F, 7'h7F, pk(4'hD, 4'hE, 0, 0, 8'd5, 3'b001));
`ifdef SEG_MONITOR_BLANK_EN
    add(0, 1, 7'h7F, 7'h7F, pk(4'h0, 4'h0, 1, 0, 8'd5, 3'b010));
`else
    add(0, 1, 7'h7F, 7'h7F, pk(4'hD, 4'hE, 0, 1, 8'd5, 3'b100));
`endif

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].tk, vecs[i].h1, vecs[i].h0);
      chk4($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Reset precedence over a tick; first acceptance of 0/0 after reset
    step(1, 1, 7'h40, 7'h40);
    chk4("reset_with_tick", RST_EXP);
    chk1("reset_with_tick", RST_EXP);
    step(0, 1, 7'h40, 7'h40);
    chk1("st1_first_tick_accept", pk(4'h0, 4'h0, 1, 0, 8'd1, 3'b010));
    chk4("settling_tick1", RST_EXP);
    step(0, 1, 7'h40, 7'h40);
    step(0, 1, 7'h40, 7'h40);
    chk4("settling_tick3", RST_EXP);
    // This tick would accept, but reset wins
    step(1, 1, 7'h40, 7'h40);
    chk4("reset_on_accept_tick", RST_EXP);
    chk1("reset_on_accept_tick", RST_EXP);
    // Settle progress must have been discarded
    for (int i = 0; i < 3; i++) step(0, 1, 7'h40, 7'h40);
    chk4("no_early_accept_after_reset", RST_EXP);
    step(0, 1, 7'h40, 7'h40);
    chk4("first_accept_equal_to_reset_val", pk(4'h0, 4'h0, 1, 0, 8'd1, 3'b010));

    // Drive changes to 255 and then wrap, alternating 1/1 and 0/0
    for (int i = 0; i < 255; i++) begin
      logic [6:0] p;
      p = (i % 2 == 0) ? 7'h79 : 7'h40;
      step(0, 1, p, p);
      if (i == 0) begin
        chk4("locked_to_settle", pk(4'h0, 4'h0, 0, 0, 8'd1, 3'b001));
        chk1("st1_locked_to_locked", pk(4'h1, 4'h1, 1, 0, 8'd2, 3'b010));
      end
      for (int k = 0; k < 3; k++) step(0, 1, p, p);
      if (i == 253) begin
        chk4("changes_255", pk(4'h0, 4'h0, 1, 0, 8'd255, 3'b010));
        chk1("changes_255", pk(4'h0, 4'h0, 1, 0, 8'd255, 3'b010));
      end
    end
    chk4("changes_wrap", pk(4'h1, 4'h1, 1, 0, 8'd0, 3'b010));
    chk1("changes_wrap", pk(4'h1, 4'h1, 1, 0, 8'd0, 3'b010));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg_monitor.md
# seg_monitor

- Receiving end of the seven-segment display path: samples the two active-low segment buses driven toward HEX0/HEX1 and decodes them back into 4-bit digit values.
- Sampling is paced by the slow tick from the clock divider.
- A pattern is accepted only after it holds stable for a programmable number of ticks.
- Illegal segment patterns are flagged, and the block counts accepted value changes.
- It sits beside the display coders, for on-board self-check and bench loopback.

## Interface

- STABLE_TICKS, 4: consecutive identical samples required for acceptance; legal range 1..15.
- clock  in  1  system clock (CLOCK50 domain)
- reset  in  1  synchronous, active-high
- tick  in  1  one-cycle sample strobe from the clock divider
- hex0  in  7  low-digit segments, active-low, bit order {g,f,e,d,c,b,a}
- hex1  in  7  high-digit segments, same encoding
- val0  out  4  last accepted low digit
- val1  out  4  last accepted high digit
- valid  out  1  accepted pattern currently held (state LOCKED)
- err  out  1  illegal pattern accepted (state FAULT)
- changes  out  8  accepted value changes, wraps 255->0
- led  out  3  {err, valid, settling}

## Operation

- Legal codes, hex value -> digit:
  - 0x40->0, 0x79->1, 0x24->2, 0x30->3, 0x19->4, 0x12->5, 0x02->6, 0x78->7
  - 0x00->8, 0x10->9, 0x08->A, 0x03->b, 0x46->C, 0x21->d, 0x06->E, 0x0E->F
- Any other 7-bit value is illegal.
- Internal registers: 14-bit candidate `cand` = {hex1,hex0}, 4-bit `stab`, state.
- States: SETTLE, LOCKED, FAULT.
- On a cycle with tick=1, sample S = {hex1,hex0}:
  - S != cand: cand<=S, stab<=1. From LOCKED or FAULT, go to SETTLE.
  - S == cand: stab increments, saturating at STABLE_TICKS.
- Acceptance happens on the tick where stab reaches STABLE_TICKS while in SETTLE:
  - Both digits legal: val0/val1 <= decoded digits; state -> LOCKED.
    - changes increments only if the decoded pair differs from the previously accepted pair, or if this is the first acceptance since reset.
  - Either digit illegal: state -> FAULT; val0/val1 hold.
- STABLE_TICKS=1: acceptance is evaluated on every tick in SETTLE, including the tick that loads a new cand.
- In LOCKED or FAULT, an equal sample changes nothing.
- tick=0: all registers hold.
- valid = (state==LOCKED); err = (state==FAULT); settling = (state==SETTLE).
- Reset values: state SETTLE, cand 14'h3FFF, stab 0, val0 0, val1 0, valid 0, err 0, changes 0, led 3'b001.
- No first-acceptance flag survives reset.

## Timing

- All outputs are registered; sampling, acceptance and output update share one clock edge.
- A pattern stable from tick k is accepted at the edge of tick k+STABLE_TICKS-1.
  - Outputs are visible the following cycle.
- A differing sample while in LOCKED drops valid at that tick's edge; val0/val1 hold their old values.
- reset and tick in the same cycle: reset wins.
- Reset mid-settle discards cand and stab.
- The tick arrival rate is unconstrained; tick held high samples every clock.
- Input glitches between ticks are not observed.

## Configuration

- SEG_MONITOR_BLANK_EN defined:
  - 7'h7F (all segments off) is legal on either digit and decodes to 0.
  - A blank-only pair {7'h7F,7'h7F} is accepted into LOCKED but never increments changes.
- Undefined:
  - 7'h7F is illegal; a blank display held STABLE_TICKS ticks enters FAULT.

## Test plan

- **Reset and first acceptance.** Reset, then hex1=0x24, hex0=0x79 with tick every cycle, STABLE_TICKS=4.
  - -> valid=1, val1=2, val0=1, changes=1 after the 4th tick, led=3'b010.
- **Glitch rejection.** Hold 0x30/0x19 for 2 ticks, 0x00 for 1 tick, then 0x30/0x19 for 4 ticks.
  - -> no acceptance until the 4th tick of the final run; val1=3, val0=4.
- **Illegal pattern.** hex0=0x7E held 4 ticks.
  - -> err=1, valid=0, val unchanged, led=3'b100.
  - Then a legal 0x40/0x40 for 4 ticks -> err=0 on the first changed tick; LOCKED with val=0/0.
- **Change counting.** Accept A/F (0x08/0x0E), disturb one tick, re-accept A/F -> changes unchanged; accept 0x21/0x06 -> changes+1.
  - Preset changes to 255 and accept a new pair -> wraps to 0.
- **Blank handling.** Hold 0x7F/0x7F for 4 ticks.
  - With SEG_MONITOR_BLANK_EN: valid=1, val=0/0, changes unchanged.
  - Without it: err=1.
- **Reset precedence.** Assert reset concurrently with the accepting tick.
  - -> all outputs equal reset values; no acceptance.
  - STABLE_TICKS=1 variant: a new legal pattern is accepted on its first tick.
